mod_vram_arbiter: RTL and testbench
===================================

# mod_vram_arbiter

Single-port video-RAM arbiter in the 25.175 MHz VGA clock domain. It shares one iCE40 block-RAM port between two requesters. The display fetch path (hex/tile renderer driven by pixel x/y) has strict priority. The host path (counter/CPU-side writer) uses a req/ack handshake and receives only slots the display does not use. It sits between the renderer, the host logic and the RAM macro, and issues every RAM command.

## Interface
- ADDR_W, 11, VRAM word address width
- DATA_W, 8, VRAM word width
- HOST_ONLY_IN_BLANK, 0, when 1 the host is granted only while in_blank=1
- in_clk_25_175_mhz  in  1  pixel clock; the only clock
- in_reset_n  in  1  reset; asynchronous assert, active-low
- in_disp_req  in  1  single-cycle display fetch strobe
- in_disp_addr  in  ADDR_W  display fetch address, valid with in_disp_req
- out_disp_data  out  DATA_W  fetched word
- out_disp_valid  out  1  one-cycle pulse, out_disp_data valid
- in_blank  in  1  high during h/v blanking
- in_host_req  in  1  host request; held until out_host_ack
- in_host_we  in  1  1=write, 0=read; stable while req
- in_host_addr  in  ADDR_W  host address; stable while req
- in_host_wdata  in  DATA_W  host write data; stable while req
- out_host_ack  out  1  one-cycle pulse, request accepted
- out_host_rdata  out  DATA_W  host read data
- out_host_rvalid  out  1  one-cycle pulse, out_host_rdata valid
- out_ram_addr  out  ADDR_W  registered RAM address
- out_ram_we  out  1  registered RAM write enable
- out_ram_wdata  out  DATA_W  registered RAM write data
- in_ram_rdata  in  DATA_W  RAM read data, 1 cycle after address edge

## Operation
- Requests are sampled at each rising edge. Grant priority is: display, then host, then idle.
- Host eligibility: in_host_req=1 and state=IDLE and (HOST_ONLY_IN_BLANK=0 or in_blank=1).
- Display grant: out_ram_addr<=in_disp_addr, out_ram_we<=0. Push tag DISP into the read pipe.
- Host grant: out_ram_addr/we/wdata<=host fields, out_host_ack<=1, state<=GAP. Reads push tag HOST. Writes push no tag.
- Idle cycle: out_ram_we<=0. out_ram_addr holds its last value.
- State machine: IDLE -> GAP on host grant. GAP -> IDLE unconditionally after one cycle. In GAP the host cannot be granted, which prevents a double grant while the host observes ack. Display grants are unaffected by state.
- Read pipe: 2-stage tag shift register {none, DISP, HOST}. At stage 2, in_ram_rdata is registered into the tagged output, and that output's valid pulses for 1 cycle.
- Display strobe coincident with host request: display wins. Host waits with no ack and no loss. Host starvation is allowed: no fairness counter.
- Host write followed by a read to the same address returns the new data. Ordering is guaranteed by a single port with in-order issue.
- Widths: no arithmetic. All addresses pass through unchanged, with no wrap logic.

## Timing
- Reset (in_reset_n=0, async): the following outputs go to 0 immediately: out_disp_valid, out_host_ack, out_host_rvalid, out_ram_we, out_ram_addr, out_ram_wdata, out_disp_data, out_host_rdata. Read-pipe tags are cleared and state=IDLE. Deassertion is synchronised externally.
- Reset mid-operation: in-flight reads are dropped, with no valid pulse after release. A host request left high is re-arbitrated after release.
- Display latency: strobe sampled at edge N -> out_disp_valid high in cycle after edge N+2. Throughput is 1 per cycle.
- Host ack: sampled at edge N -> out_host_ack high in cycle after edge N. Host must deassert or change the request at edge N+1. Maximum host rate is 1 per 2 cycles.
- Host read data: out_host_rvalid in cycle after edge N+2.
- Write reaches RAM at edge N+1.

## Structure
- Shared package vram_pkg holds:
  - the state enum {IDLE, GAP}
  - the tag enum {TAG_NONE, TAG_DISP, TAG_HOST}
  - the constant RD_LATENCY=2
- One sub-module, mod_vram_read_pipe, contains the tag shift register plus output data/valid registers, parameterised on DATA_W.
- The arbiter FSM and RAM command registers stay in mod_vram_arbiter.

## Test plan
- Display burst: strobes on 8 consecutive cycles, addr 0x000..0x007, RAM preloaded with data=addr+0x10. Expect 8 consecutive out_disp_valid pulses with data 0x10..0x17, starting 2 cycles after the first strobe.
- Host write then read: write 0x5A to 0x123, then read 0x123, with no display traffic. Expect ack 1 cycle after each request and a 1-cycle GAP between grants. The read returns 0x5A with rvalid 2 cycles after its grant.
- Contention: host read of 0x040 held while the display strobes every cycle for 10 cycles. Expect no ack during the burst, ack in the first free cycle, and correct data.
- Blank gating: HOST_ONLY_IN_BLANK=1, host write held with in_blank=0 for 20 cycles. Expect no ack. Raise in_blank and expect ack next edge.
- Reset mid-read: display strobe at edge N, in_reset_n low between edges N+1 and N+2. Expect all outputs 0 and no out_disp_valid after release.
- Interleave: display strobes every other cycle plus back-to-back host writes to 0x000..0x003. Expect all 4 acks and no lost display data. Readback confirms 4 writes.

Source files
------------

// File: rtl/vram_pkg.sv
// ----------------------------------------------------------------------------
// vram_pkg
//
// Purpose:
//   Shared types and constants for the video-RAM arbiter slice. The arbiter
//   top and its read-return pipe both import this package.
//
// Contents:
//   state_e     - arbiter state: IDLE (host may be granted) or GAP (the cycle
//                 after a host grant, during which the host sees its ack)
//   tag_e       - owner of a read in flight: none, display or host
//   RD_LATENCY  - edges from the RAM command register to the captured data
//   host_tag()  - tag pushed for a host grant (writes produce no return data)
// ----------------------------------------------------------------------------
package vram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_e;

    // One edge for the synchronous RAM to read, one edge to register the word.
    localparam int RD_LATENCY = 2;

    // Host writes never return data, so they leave a bubble in the tag pipe.
    function automatic tag_e host_tag(input logic we);
        return we ? TAG_NONE : TAG_HOST;
    endfunction

endpackage

// File: rtl/mod_vram_read_pipe.sv
// ----------------------------------------------------------------------------
// mod_vram_read_pipe
//
// Purpose:
//   Tracks which requester owns each read in flight and steers the RAM read
//   word to that requester. A tag is pushed on the same edge that registers
//   the RAM command. When the tag reaches the last stage, the RAM output is
//   valid and is captured into the matching output register. That output's
//   valid flag pulses for one cycle.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset (clears tags and outputs)
//   push_tag     in   tag_e value for the command issued this edge
//   ram_rdata    in   synchronous RAM read word
//   disp_data    out  last word returned to the display path
//   disp_valid   out  one-cycle pulse, disp_data updated
//   host_data    out  last word returned to the host path
//   host_valid   out  one-cycle pulse, host_data updated
// ----------------------------------------------------------------------------
module mod_vram_read_pipe
    import vram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        push_tag,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [DATA_W-1:0] host_data,
    output logic              host_valid
);

    tag_e              tag_q [RD_LATENCY];
    tag_e              tag_d [RD_LATENCY];
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] host_data_q, host_data_d;
    logic              host_valid_q, host_valid_d;

    // The tag shift register advances every cycle. Idle cycles push TAG_NONE,
    // so bubbles travel down the pipe exactly like real reads.
    // Each data register holds its last word; only its valid flag is a pulse.
    always_comb begin
        tag_d[0] = tag_e'(push_tag);
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        host_data_d  = host_data_q;
        host_valid_d = 1'b0;

        unique case (tag_q[RD_LATENCY-1])
            TAG_DISP: begin
                disp_data_d  = ram_rdata;
                disp_valid_d = 1'b1;
            end
            TAG_HOST: begin
                host_data_d  = ram_rdata;
                host_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset drops every read in flight, so no valid pulse can appear after
    // release for a command issued before reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            host_data_q  <= '0;
            host_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            host_data_q  <= host_data_d;
            host_valid_q <= host_valid_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign host_data  = host_data_q;
    assign host_valid = host_valid_q;

endmodule

// File: rtl/mod_vram_arbiter.sv
// ----------------------------------------------------------------------------
// mod_vram_arbiter
//
// Purpose:
//   Shares one single-port iCE40 block RAM between the display fetch path and
//   the host path, in the 25.175 MHz pixel clock domain. The display always
//   wins. The host uses a req/ack handshake and takes only the slots the
//   display leaves free, optionally only during blanking. Every RAM command is
//   registered here. Read data is steered back by mod_vram_read_pipe.
//
// Parameters:
//   ADDR_W              VRAM word address width
//   DATA_W              VRAM word width
//   HOST_ONLY_IN_BLANK  1: host is granted only while in_blank is high
//
// Ports:
//   in_clk_25_175_mhz   in   pixel clock, the only clock
//   in_reset_n          in   asynchronous active-low reset
//   in_disp_req         in   single-cycle display fetch strobe
//   in_disp_addr        in   display fetch address
//   out_disp_data       out  fetched display word
//   out_disp_valid      out  one-cycle pulse, out_disp_data valid
//   in_blank            in   high during horizontal/vertical blanking
//   in_host_req         in   host request, held until out_host_ack
//   in_host_we          in   host write enable (1 = write, 0 = read)
//   in_host_addr        in   host address
//   in_host_wdata       in   host write data
//   out_host_ack        out  one-cycle pulse, host request accepted
//   out_host_rdata      out  host read data
//   out_host_rvalid     out  one-cycle pulse, out_host_rdata valid
//   out_ram_addr        out  registered RAM address
//   out_ram_we          out  registered RAM write enable
//   out_ram_wdata       out  registered RAM write data
//   in_ram_rdata        in   RAM read data, one cycle after the address edge
// ----------------------------------------------------------------------------
module mod_vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W             = 11,
    parameter int DATA_W             = 8,
    parameter bit HOST_ONLY_IN_BLANK = 1'b0
) (
    input  logic              in_clk_25_175_mhz,
    input  logic              in_reset_n,
    input  logic              in_disp_req,
    input  logic [ADDR_W-1:0] in_disp_addr,
    output logic [DATA_W-1:0] out_disp_data,
    output logic              out_disp_valid,
    input  logic              in_blank,
    input  logic              in_host_req,
    input  logic              in_host_we,
    input  logic [ADDR_W-1:0] in_host_addr,
    input  logic [DATA_W-1:0] in_host_wdata,
    output logic              out_host_ack,
    output logic [DATA_W-1:0] out_host_rdata,
    output logic              out_host_rvalid,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic              out_ram_we,
    output logic [DATA_W-1:0] out_ram_wdata,
    input  logic [DATA_W-1:0] in_ram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              host_ack_q, host_ack_d;

    logic              host_window;
    logic              host_eligible;
    logic              host_grant;
    tag_e              push_tag;

    // The host is eligible only in IDLE. The cycle after a grant is GAP, and
    // the host still holds its request while it sees the ack. Blocking that
    // cycle stops one request from being granted twice.
    assign host_window   = !HOST_ONLY_IN_BLANK || in_blank;
    assign host_eligible = in_host_req && (state_q == IDLE) && host_window;
    assign host_grant    = host_eligible && !in_disp_req;

    // Command selection for the next edge: display first, then host, else an
    // idle cycle that keeps the last address and wdata but never writes.
    // The display ignores the state, so a losing host just keeps waiting.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        host_ack_d  = 1'b0;
        push_tag    = TAG_NONE;

        if (in_disp_req) begin
            ram_addr_d = in_disp_addr;
            push_tag   = TAG_DISP;
        end else if (host_grant) begin
            ram_addr_d  = in_host_addr;
            ram_we_d    = in_host_we;
            ram_wdata_d = in_host_wdata;
            host_ack_d  = 1'b1;
            push_tag    = host_tag(in_host_we);
        end
    end

    // GAP always lasts one cycle, which caps the host at one grant per two
    // cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = host_grant ? GAP : IDLE;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and all RAM-facing outputs share one register block, so every
    // command the RAM sees comes straight from a flop.
    always_ff @(posedge in_clk_25_175_mhz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            host_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            host_ack_q  <= host_ack_d;
        end
    end

    assign out_ram_addr  = ram_addr_q;
    assign out_ram_we    = ram_we_q;
    assign out_ram_wdata = ram_wdata_q;
    assign out_host_ack  = host_ack_q;

    mod_vram_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk        (in_clk_25_175_mhz),
        .rst_n      (in_reset_n),
        .push_tag   (push_tag),
        .ram_rdata  (in_ram_rdata),
        .disp_data  (out_disp_data),
        .disp_valid (out_disp_valid),
        .host_data  (out_host_rdata),
        .host_valid (out_host_rvalid)
    );

endmodule

// File: tb/tb_mod_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mod_vram_arbiter
//
// Purpose:
//   Scoreboard bench for mod_vram_arbiter. Stimulus tasks push the expected
//   response, with the cycle it should appear in, into per-output queues. A
//   negedge monitor pops and compares whenever the DUT raises a valid or ack.
//   A behavioural synchronous RAM sits behind the main instance. A second
//   instance with HOST_ONLY_IN_BLANK=1 covers blank gating.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mod_vram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    typedef struct {
        int               cyc;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              in_blank = 1'b0;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              blank_host_req = 1'b0;

    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    logic [DATA_W-1:0] b_disp_data;
    logic              b_disp_valid;
    logic              b_host_ack;
    logic [DATA_W-1:0] b_host_rdata;
    logic              b_host_rvalid;
    logic [ADDR_W-1:0] b_ram_addr;
    logic              b_ram_we;
    logic [DATA_W-1:0] b_ram_wdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    exp_t disp_q[$];
    exp_t host_rd_q[$];
    int   ack_q[$];
    int   blank_ack_q[$];

    mod_vram_arbiter #(
        .ADDR_W             (ADDR_W),
        .DATA_W             (DATA_W),
        .HOST_ONLY_IN_BLANK (1'b0)
    ) dut (
        .in_clk_25_175_mhz (clk),
        .in_reset_n        (rst_n),
        .in_disp_req       (disp_req),
        .in_disp_addr      (disp_addr),
        .out_disp_data     (disp_data),
        .out_disp_valid    (disp_valid),
        .in_blank          (in_blank),
        .in_host_req       (host_req),
        .in_host_we        (host_we),
        .in_host_addr      (host_addr),
        .in_host_wdata     (host_wdata),
        .out_host_ack      (host_ack),
        .out_host_rdata    (host_rdata),
        .out_host_rvalid   (host_rvalid),
        .out_ram_addr      (ram_addr),
        .out_ram_we        (ram_we),
        .out_ram_wdata     (ram_wdata),
        .in_ram_rdata      (ram_rdata)
    );

    mod_vram_arbiter #(
        .ADDR_W             (ADDR_W),
        .DATA_W             (DATA_W),
        .HOST_ONLY_IN_BLANK (1'b1)
    ) dut_blank (
        .in_clk_25_175_mhz (clk),
        .in_reset_n        (rst_n),
        .in_disp_req       (1'b0),
        .in_disp_addr      ('0),
        .out_disp_data     (b_disp_data),
        .out_disp_valid    (b_disp_valid),
        .in_blank          (in_blank),
        .in_host_req       (blank_host_req),
        .in_host_we        (host_we),
        .in_host_addr      (host_addr),
        .in_host_wdata     (host_wdata),
        .out_host_ack      (b_host_ack),
        .out_host_rdata    (b_host_rdata),
        .out_host_rvalid   (b_host_rvalid),
        .out_ram_addr      (b_ram_addr),
        .out_ram_we        (b_ram_we),
        .out_ram_wdata     (b_ram_wdata),
        .in_ram_rdata      (8'h00)
    );

    // 40 ns period stands in for the 39.7 ns pixel clock.
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-before-write, preloaded with addr+0x10.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = 8'(i + 16'h0010);
        end
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one display strobe this cycle. Its word is due three counts later:
    // sampled on the next edge, read by the RAM on the one after, and
    // registered on the third.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] exp_data);
        exp_t e;
        disp_req  = 1'b1;
        disp_addr = addr;
        e.cyc     = cyc + 3;
        e.data    = exp_data;
        disp_q.push_back(e);
    endtask

    // Issues one host request and holds it until ack, then drops it after the
    // following edge. ack_delay is the hand-computed number of edges to the
    // grant.
    task automatic applyHostStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] wdata,
                                     input int ack_delay,
                                     input logic [DATA_W-1:0] exp_rdata);
        exp_t e;
        bit   got;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        ack_q.push_back(cyc + ack_delay);
        if (!we) begin
            e.cyc  = cyc + ack_delay + 2;
            e.data = exp_rdata;
            host_rd_q.push_back(e);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (host_ack) got = 1'b1;
        end
        if (!got) checkOutput("host_ack_timeout", 32'd0, 32'd1);
        step();
        host_req = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        checkOutput({tag, "_host_ack"}, 32'(host_ack), 32'd0);
        checkOutput({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        checkOutput({tag, "_disp_data"}, 32'(disp_data), 32'd0);
        checkOutput({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    endtask

    // Monitor: every valid or ack pulse must match the head of its queue, in
    // both cycle and data. A pulse with nothing queued is a failure.
    exp_t mon_e;
    int   mon_c;
    always @(negedge clk) begin
        if (rst_n) begin
            if (disp_valid) begin
                if (disp_q.size() == 0) begin
                    checkOutput("unexpected_disp_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = disp_q.pop_front();
                    checkOutput("disp_cycle", 32'(cyc), 32'(mon_e.cyc));
                    checkOutput("disp_data", 32'(disp_data), 32'(mon_e.data));
                end
            end
            if (host_rvalid) begin
                if (host_rd_q.size() == 0) begin
                    checkOutput("unexpected_host_rvalid", 32'd1, 32'd0);
                end else begin
                    mon_e = host_rd_q.pop_front();
                    checkOutput("host_rd_cycle", 32'(cyc), 32'(mon_e.cyc));
                    checkOutput("host_rdata", 32'(host_rdata), 32'(mon_e.data));
                end
            end
            if (host_ack) begin
                if (ack_q.size() == 0) begin
                    checkOutput("unexpected_host_ack", 32'd1, 32'd0);
                end else begin
                    mon_c = ack_q.pop_front();
                    checkOutput("host_ack_cycle", 32'(cyc), 32'(mon_c));
                end
            end
            if (b_host_ack) begin
                if (blank_ack_q.size() == 0) begin
                    checkOutput("unexpected_blank_ack", 32'd1, 32'd0);
                end else begin
                    mon_c = blank_ack_q.pop_front();
                    checkOutput("blank_ack_cycle", 32'(cyc), 32'(mon_c));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;

        // Reset state
        #2 rst_n = 1'b0;
        #3 checkAllZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        step();

        // Display burst: 8 back-to-back strobes, data = addr + 0x10
        for (int k = 0; k < 8; k++) begin
            applyStimulus(ADDR_W'(k), 8'(8'h10 + k));
            step();
        end
        disp_req = 1'b0;
        repeat (5) step();

        // Host write then read of the same address, no display traffic
        applyHostStimulus(1'b1, 11'h123, 8'h5A, 1, 8'h00);
        applyHostStimulus(1'b0, 11'h123, 8'h00, 1, 8'h5A);
        repeat (5) step();

        // Contention: host read held under a 10-cycle display burst
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    applyStimulus(ADDR_W'(11'h200 + k), 8'(8'h10 + k));
                    step();
                end
                disp_req = 1'b0;
            end
            applyHostStimulus(1'b0, 11'h040, 8'h00, 11, 8'h50);
        join
        repeat (5) step();

        // Interleave: display every other cycle, back-to-back host writes
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    applyStimulus(ADDR_W'(11'h100 + k), 8'(8'h10 + k));
                    step();
                    disp_req = 1'b0;
                    step();
                end
            end
            begin
                applyHostStimulus(1'b1, 11'h000, 8'hA0, 2, 8'h00);
                applyHostStimulus(1'b1, 11'h001, 8'hA1, 1, 8'h00);
                applyHostStimulus(1'b1, 11'h002, 8'hA2, 1, 8'h00);
                applyHostStimulus(1'b1, 11'h003, 8'hA3, 1, 8'h00);
            end
        join
        for (int k = 0; k < 4; k++) begin
            applyHostStimulus(1'b0, ADDR_W'(k), 8'h00, 1, 8'(8'hA0 + k));
        end
        repeat (5) step();

        // Blank gating on the HOST_ONLY_IN_BLANK instance
        host_we        = 1'b1;
        host_addr      = 11'h010;
        host_wdata     = 8'h77;
        in_blank       = 1'b0;
        blank_host_req = 1'b1;
        repeat (20) step();
        in_blank = 1'b1;
        blank_ack_q.push_back(cyc + 1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (b_host_ack) got = 1'b1;
        end
        if (!got) checkOutput("blank_ack_timeout", 32'd0, 32'd1);
        step();
        blank_host_req = 1'b0;
        in_blank       = 1'b0;
        repeat (3) step();

        // Reset mid-read: the strobe's data must never come back
        disp_req  = 1'b1;
        disp_addr = 11'h300;
        step();
        disp_req = 1'b0;
        step();
        rst_n = 1'b0;
        #2 checkAllZero("midreset");
        @(negedge clk) rst_n = 1'b1;
        repeat (8) step();

        // Everything queued must have been seen
        checkOutput("disp_q_empty", 32'(disp_q.size()), 32'd0);
        checkOutput("host_rd_q_empty", 32'(host_rd_q.size()), 32'd0);
        checkOutput("ack_q_empty", 32'(ack_q.size()), 32'd0);
        checkOutput("blank_ack_q_empty", 32'(blank_ack_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
